// File: rtl/tdm_demux_2ch.sv
// Receive side of a 2:1 TDM link: splits an interleaved stream with a channel-0
// start-of-frame marker into registered channel pairs and tracks frame alignment.
//
// state | meaning
// HUNT  | unaligned, waiting for a sof-marked channel-0 sample
// EXP1  | channel 0 held in hold0, expecting the channel-1 sample
// EXP0  | frame completed, expecting the next sof-marked channel-0 sample
module tdm_demux_2ch #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic             out_valid,
    output logic             sync_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        EXP1 = 2'd1,
        EXP0 = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] hold0;
    logic             load_hold;
    logic             load_out;
    logic             err_det;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            hold0     <= '0;
            y0        <= '0;
            y1        <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            locked    <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_n;
            out_valid <= load_out;
            sync_err  <= err_det;
            if (load_hold) begin
                hold0 <= din;
            end
            if (load_out) begin
                y0 <= hold0;
                y1 <= din;
            end
            // An error and a completed frame cannot come from the same sample.
            if (err_det) begin
                locked <= 1'b0;
            end else if (load_out) begin
                locked <= 1'b1;
            end
            if (err_det && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

    always_comb begin
        state_n   = state;
        load_hold = 1'b0;
        load_out  = 1'b0;
        err_det   = 1'b0;
        if (din_valid) begin
            unique case (state)
                HUNT: begin
                    if (sof) begin
                        load_hold = 1'b1;
                        state_n   = EXP1;
                    end
                end
                EXP1: begin
                    if (sof) begin
                        // Double marker: re-anchor on the newer frame.
                        err_det   = 1'b1;
                        load_hold = 1'b1;
                    end else begin
                        load_out = 1'b1;
                        state_n  = EXP0;
                    end
                end
                EXP0: begin
                    if (sof) begin
                        load_hold = 1'b1;
                        state_n   = EXP1;
                    end else begin
                        err_det = 1'b1;
                        state_n = HUNT;
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

endmodule

// File: doc/tdm_demux_2ch.md
# tdm_demux_2ch

Two-channel time-division demultiplexer: the receive end of a 2:1 time-multiplexed link. It accepts an interleaved sample stream with a start-of-frame marker on the channel-0 slot. It splits the stream back into two channel outputs, presented as one registered pair per frame. It also tracks frame alignment and reports slot errors. It sits downstream of a 2:1 mux whose select toggles once per sample.

## Interface

- WIDTH, 8, sample width in bits.
- ERR_W, 8, width of the saturating error counter.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  multiplexed sample.
- din_valid  input  1  din carries a sample this cycle. A low cycle is an idle gap with no effect.
- sof  input  1  start of frame. Meaningful only with din_valid; marks the channel-0 sample.
- y0  output  WIDTH  channel-0 sample of the last complete frame.
- y1  output  WIDTH  channel-1 sample of the last complete frame.
- out_valid  output  1  one-cycle pulse: y0/y1 updated.
- sync_err  output  1  one-cycle pulse: slot/marker mismatch detected.
- locked  output  1  high once a complete frame is received; cleared on any error.
- err_cnt  output  ERR_W  count of sync_err pulses, saturating at all-ones.

## Operation

- Internal state: hold0 (WIDTH), holding the pending channel-0 sample.
- FSM states: HUNT, EXP1 (channel 0 held, expecting channel 1), EXP0 (locked, expecting next frame).
- An accepted sample is din_valid=1 at a rising edge. All transitions below occur only on accepted samples. With din_valid=0, the state, hold0, y0/y1, locked and err_cnt hold.
- HUNT:
  - sof=1: hold0<=din, go to EXP1.
  - sof=0: discard the sample, stay in HUNT, no error.
- EXP1:
  - sof=0: y0<=hold0, y1<=din, out_valid pulses, locked<=1, go to EXP0.
  - sof=1: double marker. sync_err pulses, locked<=0, hold0<=din (re-anchor on the new frame), stay in EXP1.
- EXP0:
  - sof=1: hold0<=din, go to EXP1. locked stays 1.
  - sof=0: missing marker. sync_err pulses, locked<=0, discard the sample, go to HUNT.
- err_cnt increments by 1 on every sync_err and holds at 2^ERR_W-1.
- y0/y1 change only on a completed frame. They hold their values across errors and gaps.
- No timeout: an arbitrarily long gap in any state is legal.

## Timing

- Reset values: state=HUNT, hold0=0, y0=0, y1=0, out_valid=0, sync_err=0, locked=0, err_cnt=0.
- rst dominates: with rst=1 at an edge, din_valid is ignored and all registers take their reset values.
- A reset mid-frame discards hold0. The first post-reset sample must carry sof=1 to start a frame.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency:
  - y0/y1/out_valid update on the same edge that accepts the channel-1 sample, so they are visible in the following cycle.
  - out_valid is high for exactly one cycle per frame.
- sync_err is high for exactly one cycle, following the edge that accepted the offending sample. locked falls on that same edge.
- err_cnt updates on the same edge as sync_err.
- Back-to-back operation: with din_valid held high and sof toggling 1,0,1,0, the block delivers one out_valid every 2 cycles with no bubbles.
- out_valid and sync_err are never high in the same cycle.

## Test plan

- Reset then clean stream:
  - Stimulus: (0x11, sof=1), (0x22, sof=0), (0x33, sof=1), (0x44, sof=0), back-to-back.
  - Response: out_valid pulses on cycles 2 and 4; y0/y1 = 0x11/0x22, then 0x33/0x44.
  - locked rises with the first pulse. sync_err never asserts; err_cnt=0.
- Gaps:
  - Stimulus: the same stream with din_valid=0 for 3 cycles between every sample.
  - Response: identical y0/y1 values; out_valid pulses once per frame.
  - Outputs are stable during the gaps.
- Double marker:
  - Stimulus: (0xA0, sof=1), then (0xB0, sof=1), then (0xB1, sof=0).
  - Response: one sync_err pulse and err_cnt=1, then y0/y1 = 0xB0/0xB1 with out_valid.
- Missing marker:
  - Stimulus: after lock, (0xC0, sof=0), (0xC1, sof=0), (0xD0, sof=1), (0xD1, sof=0).
  - Response: one sync_err and locked=0; 0xC1 is discarded silently in HUNT.
  - Then y0/y1 = 0xD0/0xD1 and locked=1.
- Reset mid-frame:
  - Stimulus: assert rst after (0xE0, sof=1); then send (0xE1, sof=0), (0xF0, sof=1), (0xF1, sof=0).
  - Response: y0/y1 = 0/0 after reset; 0xE1 is ignored.
  - Then y0/y1 = 0xF0/0xF1 with out_valid.
- Counter saturation (ERR_W=2):
  - Stimulus: 5 consecutive double markers.
  - Response: err_cnt reads 1, 2, 3, 3, 3; sync_err pulses all 5 times.
